writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage; consumes the memory stage's result bundle (opcode, funct3, rd address/data/write-enable, raw load word, ce/stall/flush).
- Formats load data (byte/half select, sign/zero extension) and checks load alignment.
- Registers one register-file write per retired instruction.
- Drives the register-file write port and forwarding path, and keeps a retired-instruction counter.

Parameters:
- DWIDTH, 32, data width of register file and load word
- AWIDTH, 5, register address width
- FUNCT_WIDTH, 3, funct3 width
- CNT_WIDTH, 32, retired-instruction counter width

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  reset, asynchronous, active-low
- wb_i_ce  in  1  memory stage holds a valid instruction
- wb_i_stall  in  1  upstream stall
- wb_i_flush  in  1  kill instruction in flight
- wb_i_opcode  in  `OPCODE_WIDTH  one-hot opcode from memory stage
- wb_i_funct3  in  FUNCT_WIDTH  load size/sign selector
- wb_i_rd_addr  in  AWIDTH  destination register
- wb_i_rd_data  in  DWIDTH  non-load result (ALU/PC+4)
- wb_i_rd_we  in  1  instruction writes rd
- wb_i_load_data  in  DWIDTH  raw aligned word from data memory
- wb_i_addr_lo  in  2  byte offset of load address (alu_value[1:0])
- wb_o_rd_addr  out  AWIDTH  register-file write address
- wb_o_rd_data  out  DWIDTH  register-file write data
- wb_o_rd_we  out  1  register-file write strobe
- wb_o_valid  out  1  an instruction retired this cycle
- wb_o_err  out  1  misaligned/illegal load detected (1-cycle pulse)
- wb_o_ce  out  1  registered ce
- wb_o_stall  out  1  registered stall
- wb_o_retired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (wb_rst=0, async): all outputs 0, counter 0.
- Accept condition: acc = wb_i_ce & ~wb_i_stall & ~wb_i_flush. Latency is 1: inputs sampled at edge N drive the outputs for the cycle after edge N.
- Flush has priority over ce and stall. On flush at edge N: rd_we=0, valid=0, err=0, and rd_addr/rd_data hold their previous values.
- No acc (bubble/stall): rd_we=0, valid=0, err=0, and address/data hold. A write is asserted for exactly one cycle per instruction and is never repeated during a stall.
- Load (opcode LOAD bit set) write-data select, with off = wb_i_addr_lo:
  - funct3 000 LB: sext(byte[off])
  - funct3 001 LH: sext(half[off[1]])
  - funct3 010 LW: full word
  - funct3 100 LBU: zext(byte[off])
  - funct3 101 LHU: zext(half[off[1]])
- Load error conditions:
  - LH/LHU with off[0]=1, LW with off!=0, or load funct3 011/110/111.
  - Effect: err=1, rd_we=0, valid=1 (retires, counts), rd_data=0.
- Non-load: rd_data = wb_i_rd_data.
- rd_we = wb_i_rd_we & acc & ~err & (wb_i_rd_addr != 0). x0 is never written.
- Counter: +1 on each edge where acc; wraps modulo 2^CNT_WIDTH silently.
- wb_o_ce and wb_o_stall are registered copies of the inputs; both reset to 0.
- Reset asserted mid-operation clears everything immediately, with no pending write.

Decomposition:
- Shared package/header: `OPCODE_WIDTH, one-hot LOAD bit index, funct3 encodings (LB/LH/LW/LBU/LHU), and the ALU width macro already used by the pipeline.
- One combinational sub-module `load_formatter` (funct3, offset, raw word -> formatted data, misalign/illegal flag). The stage register, flush/stall control and counter live in writeback_stage.

Test Plan:
- Reset mid-run: pulse wb_rst=0 asynchronously between edges -> all outputs 0 immediately, and after release the counter restarts from 0.
- LB/LBU with load_data=0x80FF7F01:
  - LB, off=3 -> rd_data=0xFFFFFF80.
  - LBU, off=3 -> 0x00000080.
  - LB, off=1 -> 0x0000007F.
  - In each case rd_we=1 for one cycle after the accepting edge.
- Same load_data with LH, off=2 -> 0xFFFF80FF; LHU, off=0 -> 0x00007F01; LW, off=1 -> err=1, rd_we=0, counter +1.
- ALU result 0x12345678 to rd=5, then wb_i_stall=1 for 3 cycles -> one write (addr 5, data 0x12345678), then rd_we=0 with addr/data held; counter +1 only.
- rd_addr=0 with rd_we=1, data 0xDEADBEEF -> rd_we=0 and valid=1. Next cycle, flush=1 together with ce=1 -> valid=0, rd_we=0, counter unchanged.
- CNT_WIDTH=4: 17 back-to-back accepted instructions -> counter sequence 1..15, 0, 1 (wrap).

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: opcode layout,
// load funct3 encodings and pipeline-wide widths.
package writeback_stage_pkg;

   localparam int OPCODE_WIDTH = 11;
   localparam int ALU_WIDTH    = 32;

   // one-hot opcode bit positions
   localparam int OP_RTYPE  = 0;
   localparam int OP_ITYPE  = 1;
   localparam int OP_LOAD   = 2;
   localparam int OP_STORE  = 3;
   localparam int OP_BRANCH = 4;
   localparam int OP_JAL    = 5;
   localparam int OP_JALR   = 6;
   localparam int OP_LUI    = 7;
   localparam int OP_AUIPC  = 8;
   localparam int OP_SYSTEM = 9;
   localparam int OP_FENCE  = 10;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_f3_e;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Load data formatter: byte/half/word select with sign or zero
// extension, plus misaligned / illegal-size detection.
module load_formatter
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        off,
   input  logic [DWIDTH-1:0] word,
   output logic [DWIDTH-1:0] data,
   output logic              err
);

   logic [7:0]  b_sel;
   logic [15:0] h_sel;
   logic        is_lb;
   logic        is_lh;
   logic        is_lw;
   logic        is_lbu;
   logic        is_lhu;
   logic        mis;

   assign b_sel = word[{off, 3'b000} +: 8];
   assign h_sel = word[{off[1], 4'b0000} +: 16];

   assign is_lb  = (funct3 == F3_LB);
   assign is_lh  = (funct3 == F3_LH);
   assign is_lw  = (funct3 == F3_LW);
   assign is_lbu = (funct3 == F3_LBU);
   assign is_lhu = (funct3 == F3_LHU);

   assign mis = ((is_lh | is_lhu) & off[0])
              | (is_lw & (off != 2'b00));

   always_comb begin
      data = '0;
      err  = 1'b0;
      unique case (1'b1)
         is_lb:  data = {{(DWIDTH-8){b_sel[7]}}, b_sel};
         is_lh:  data = {{(DWIDTH-16){h_sel[15]}}, h_sel};
         is_lw:  data = word;
         is_lbu: data = {{(DWIDTH-8){1'b0}}, b_sel};
         is_lhu: data = {{(DWIDTH-16){1'b0}}, h_sel};
         default: err = 1'b1;
      endcase
      // a faulting load never leaks partial data to the regfile
      if (mis) begin
         err  = 1'b1;
         data = '0;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: formats load results, registers one
// regfile write per retired instruction, counts retirements.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 5,
   parameter int FUNCT_WIDTH = 3,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                    wb_clk,
   input  logic                    wb_rst,
   input  logic                    wb_i_ce,
   input  logic                    wb_i_stall,
   input  logic                    wb_i_flush,
   input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
   input  logic [FUNCT_WIDTH-1:0]  wb_i_funct3,
   input  logic [AWIDTH-1:0]       wb_i_rd_addr,
   input  logic [DWIDTH-1:0]       wb_i_rd_data,
   input  logic                    wb_i_rd_we,
   input  logic [DWIDTH-1:0]       wb_i_load_data,
   input  logic [1:0]              wb_i_addr_lo,
   output logic [AWIDTH-1:0]       wb_o_rd_addr,
   output logic [DWIDTH-1:0]       wb_o_rd_data,
   output logic                    wb_o_rd_we,
   output logic                    wb_o_valid,
   output logic                    wb_o_err,
   output logic                    wb_o_ce,
   output logic                    wb_o_stall,
   output logic [CNT_WIDTH-1:0]    wb_o_retired
);

   logic              acc;
   logic              ld;
   logic              fmt_err;
   logic              ld_err;
   logic              wr;
   logic [DWIDTH-1:0] fmt_data;
   logic [DWIDTH-1:0] nxt_data;
   logic              unused_op;

   // only the LOAD bit steers this stage
   assign unused_op = ^{wb_i_opcode[OPCODE_WIDTH-1:OP_LOAD+1],
                        wb_i_opcode[OP_LOAD-1:0]};

   load_formatter #(
      .DWIDTH (DWIDTH)
   ) u_fmt (
      .funct3 (wb_i_funct3[2:0]),
      .off    (wb_i_addr_lo),
      .word   (wb_i_load_data),
      .data   (fmt_data),
      .err    (fmt_err)
   );

   assign acc    = wb_i_ce & ~wb_i_stall & ~wb_i_flush;
   assign ld     = wb_i_opcode[OP_LOAD];
   assign ld_err = ld & fmt_err;

   assign nxt_data = ld_err ? '0
                   : ld     ? fmt_data
                   :          wb_i_rd_data;

   assign wr = wb_i_rd_we & ~ld_err
             & (wb_i_rd_addr != '0);

   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         wb_o_rd_addr <= '0;
         wb_o_rd_data <= '0;
         wb_o_rd_we   <= 1'b0;
         wb_o_valid   <= 1'b0;
         wb_o_err     <= 1'b0;
         wb_o_ce      <= 1'b0;
         wb_o_stall   <= 1'b0;
         wb_o_retired <= '0;
      end else begin
         wb_o_ce    <= wb_i_ce;
         wb_o_stall <= wb_i_stall;
         // strobes are single-cycle; address/data hold on bubbles
         wb_o_rd_we <= 1'b0;
         wb_o_valid <= 1'b0;
         wb_o_err   <= 1'b0;
         if (acc) begin
            wb_o_rd_addr <= wb_i_rd_addr;
            wb_o_rd_data <= nxt_data;
            wb_o_rd_we   <= wr;
            wb_o_valid   <= 1'b1;
            wb_o_err     <= ld_err;
            wb_o_retired <= wb_o_retired + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver pushes expected
// outputs per cycle, monitor pops and compares after each edge.
module tb_writeback_stage;
   import writeback_stage_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int FW = 3;
   localparam int CW = 4;

   localparam logic [OPCODE_WIDTH-1:0] OPC_LD  = 11'b000_0000_0100;
   localparam logic [OPCODE_WIDTH-1:0] OPC_ALU = 11'b000_0000_0010;
   localparam logic [DW-1:0]           LDW     = 32'h80FF7F01;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    i_ce = 1'b0;
   logic                    i_stall = 1'b0;
   logic                    i_flush = 1'b0;
   logic [OPCODE_WIDTH-1:0] i_opcode = '0;
   logic [FW-1:0]           i_funct3 = '0;
   logic [AW-1:0]           i_rd_addr = '0;
   logic [DW-1:0]           i_rd_data = '0;
   logic                    i_rd_we = 1'b0;
   logic [DW-1:0]           i_load_data = '0;
   logic [1:0]              i_addr_lo = '0;
   logic [AW-1:0]           o_rd_addr;
   logic [DW-1:0]           o_rd_data;
   logic                    o_rd_we;
   logic                    o_valid;
   logic                    o_err;
   logic                    o_ce;
   logic                    o_stall;
   logic [CW-1:0]           o_retired;

   writeback_stage #(
      .DWIDTH      (DW),
      .AWIDTH      (AW),
      .FUNCT_WIDTH (FW),
      .CNT_WIDTH   (CW)
   ) dut (
      .wb_clk         (clk),
      .wb_rst         (rst),
      .wb_i_ce        (i_ce),
      .wb_i_stall     (i_stall),
      .wb_i_flush     (i_flush),
      .wb_i_opcode    (i_opcode),
      .wb_i_funct3    (i_funct3),
      .wb_i_rd_addr   (i_rd_addr),
      .wb_i_rd_data   (i_rd_data),
      .wb_i_rd_we     (i_rd_we),
      .wb_i_load_data (i_load_data),
      .wb_i_addr_lo   (i_addr_lo),
      .wb_o_rd_addr   (o_rd_addr),
      .wb_o_rd_data   (o_rd_data),
      .wb_o_rd_we     (o_rd_we),
      .wb_o_valid     (o_valid),
      .wb_o_err       (o_err),
      .wb_o_ce        (o_ce),
      .wb_o_stall     (o_stall),
      .wb_o_retired   (o_retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic          valid;
      logic          err;
      logic          ce;
      logic          stall;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [CW-1:0] cnt;
      string         tag;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int errors = 0;
   int checks = 0;

   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic [CW-1:0] m_cnt  = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(string tag, logic ce, logic stall, logic flush,
                       logic [OPCODE_WIDTH-1:0] op, logic [2:0] f3,
                       logic [AW-1:0] addr, logic [DW-1:0] data,
                       logic we, logic [1:0] off,
                       logic [DW-1:0] exp_data, logic exp_err);
      exp_t e;
      @(negedge clk);
      i_ce = ce;
      i_stall = stall;
      i_flush = flush;
      i_opcode = op;
      i_funct3 = f3;
      i_rd_addr = addr;
      i_rd_data = data;
      i_rd_we = we;
      i_load_data = LDW;
      i_addr_lo = off;
      e.tag = tag;
      e.ce = ce;
      e.stall = stall;
      if (ce && !stall && !flush) begin
         m_cnt = m_cnt + 1'b1;
         m_addr = addr;
         m_data = exp_data;
         e.we = we && !exp_err && (addr != 0);
         e.valid = 1'b1;
         e.err = exp_err;
      end else begin
         e.we = 1'b0;
         e.valid = 1'b0;
         e.err = 1'b0;
      end
      e.addr = m_addr;
      e.data = m_data;
      e.cnt = m_cnt;
      q.push_back(e);
   endtask

   task automatic ld(string tag, logic [2:0] f3, logic [1:0] off,
                     logic [DW-1:0] exp_data, logic exp_err);
      step(tag, 1, 0, 0, OPC_LD, f3, 5'd7, 32'hAAAA5555, 1, off,
           exp_data, exp_err);
   endtask

   task automatic alu(string tag, logic [AW-1:0] addr,
                      logic [DW-1:0] data, logic we);
      step(tag, 1, 0, 0, OPC_ALU, 3'b000, addr, data, we, 2'b00,
           data, 1'b0);
   endtask

   task automatic idle(string tag);
      step(tag, 0, 0, 0, '0, 3'b000, 5'd0, 32'h0, 0, 2'b00,
           32'h0, 1'b0);
   endtask

   task automatic check_zero(string tag);
      chk({tag, ".addr"}, 32'(o_rd_addr), 32'h0);
      chk({tag, ".data"}, o_rd_data, 32'h0);
      chk({tag, ".we"}, 32'(o_rd_we), 32'h0);
      chk({tag, ".valid"}, 32'(o_valid), 32'h0);
      chk({tag, ".err"}, 32'(o_err), 32'h0);
      chk({tag, ".ce"}, 32'(o_ce), 32'h0);
      chk({tag, ".stall"}, 32'(o_stall), 32'h0);
      chk({tag, ".cnt"}, 32'(o_retired), 32'h0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rst && q.size() > 0) begin
         me = q.pop_front();
         chk({me.tag, ".we"}, 32'(o_rd_we), 32'(me.we));
         chk({me.tag, ".valid"}, 32'(o_valid), 32'(me.valid));
         chk({me.tag, ".err"}, 32'(o_err), 32'(me.err));
         chk({me.tag, ".addr"}, 32'(o_rd_addr), 32'(me.addr));
         chk({me.tag, ".data"}, o_rd_data, me.data);
         chk({me.tag, ".cnt"}, 32'(o_retired), 32'(me.cnt));
         chk({me.tag, ".ce"}, 32'(o_ce), 32'(me.ce));
         chk({me.tag, ".stall"}, 32'(o_stall), 32'(me.stall));
      end
   end

   initial begin
      #1 rst = 1'b0;
      #2 check_zero("por");
      @(negedge clk);
      rst = 1'b1;

      ld("lb3", 3'b000, 2'd3, 32'hFFFFFF80, 0);
      ld("lbu3", 3'b100, 2'd3, 32'h00000080, 0);
      ld("lb1", 3'b000, 2'd1, 32'h0000007F, 0);
      idle("idle_after_lb");
      ld("lh2", 3'b001, 2'd2, 32'hFFFF80FF, 0);
      ld("lhu0", 3'b100 | 3'b001, 2'd0, 32'h00007F01, 0);
      ld("lw1", 3'b010, 2'd1, 32'h0, 1);
      ld("lw0", 3'b010, 2'd0, 32'h80FF7F01, 0);
      ld("lh1", 3'b001, 2'd1, 32'h0, 1);
      ld("lbu0", 3'b100, 2'd0, 32'h00000001, 0);
      ld("f3_011", 3'b011, 2'd0, 32'h0, 1);
      ld("lb2", 3'b000, 2'd2, 32'hFFFFFFFF, 0);
      idle("idle_after_ld");

      alu("alu5", 5'd5, 32'h12345678, 1);
      for (int i = 0; i < 3; i++)
         step("stall", 1, 1, 0, OPC_ALU, 3'b000, 5'd9, 32'hCAFEF00D,
              1, 2'b00, 32'h0, 0);
      idle("after_stall");
      alu("nowe", 5'd3, 32'h0BADF00D, 0);

      alu("x0", 5'd0, 32'hDEADBEEF, 1);
      step("flush", 1, 0, 1, OPC_ALU, 3'b000, 5'd6, 32'h11111111,
           1, 2'b00, 32'h0, 0);
      step("flush_stall", 1, 1, 1, OPC_LD, 3'b010, 5'd6, 32'h0,
           1, 2'b00, 32'h0, 0);

      alu("pre_rst", 5'd4, 32'h44444444, 1);
      @(negedge clk);
      i_ce = 1'b0;
      i_rd_we = 1'b0;
      #2 rst = 1'b0;
      #1 check_zero("mid_rst");
      @(negedge clk);
      rst = 1'b1;
      m_addr = '0;
      m_data = '0;
      m_cnt = '0;

      for (int i = 0; i < 17; i++)
         alu("wrap", 5'(i % 31 + 1), 32'(i) * 32'h01010101, 1);
      idle("tail");

      repeat (3) @(negedge clk);
      chk("drain", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
